imm_ext_pipe: RTL and testbench

- Parametrised, registered successor to the decode-stage immediate extender.
- Takes an immediate field, a jump index, a PC and an op code, and computes the extended operand or the full branch/jump target.
- Holds the result in a one-stage output register backed by a one-entry skid buffer, with valid/ready handshakes and a flush.
- Sits between the D-stage decoder and the D/E pipeline register, so upstream can stall without losing results.

---
 rtl/imm_ext_pkg.sv | 17 +
 rtl/imm_ext_core.sv | 60 ++++++
 rtl/imm_ext_pipe.sv | 124 ++++++++++++
 tb/tb_imm_ext_pipe.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared op codes and default widths for the immediate extender pipeline.
package imm_ext_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_IMM_W  = 16;
  localparam int unsigned DEF_JIDX_W = 26;
  localparam int unsigned OP_W       = 3;
  localparam int unsigned DEF_OP_W   = OP_W;

  localparam logic [OP_W-1:0] OP_ZERO = 3'd0;
  localparam logic [OP_W-1:0] OP_SIGN = 3'd1;
  localparam logic [OP_W-1:0] OP_LUI  = 3'd2;
  localparam logic [OP_W-1:0] OP_SOFS = 3'd3;
  localparam logic [OP_W-1:0] OP_JUMP = 3'd4;
  localparam logic [OP_W-1:0] OP_BTGT = 3'd5;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational op decode and arithmetic: extended immediate or branch/jump target.
// IMM_EXT_OVF_EN adds the ovf output (target wrap detection).
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IMM_W  = DEF_IMM_W,
  parameter int unsigned JIDX_W = DEF_JIDX_W,
  parameter int unsigned OP_W   = DEF_OP_W
) (
  input  logic [OP_W-1:0]   op,
  input  logic [IMM_W-1:0]  imm,
  input  logic [JIDX_W-1:0] jidx,
  input  logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] data,
`ifdef IMM_EXT_OVF_EN
  output logic              ovf,
`endif
  output logic              illegal
);

  logic [DATA_W-1:0] pc4;
  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] sofs;

  always_comb begin
    pc4     = pc + DATA_W'(4);
    sext    = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    sofs    = sext << 2;
    data    = '0;
    illegal = 1'b0;
    case (op)
      OP_ZERO: data = {{(DATA_W-IMM_W){1'b0}}, imm};
      OP_SIGN: data = sext;
      OP_LUI:  data = {imm, {(DATA_W-IMM_W){1'b0}}};
      OP_SOFS: data = sofs;
      OP_JUMP: data = {pc4[DATA_W-1:JIDX_W+2], jidx, 2'b00};
      OP_BTGT: data = pc4 + sofs;
      default: illegal = 1'b1;
    endcase
  end

`ifdef IMM_EXT_OVF_EN
  // Three guard bits hold the unbounded signed target; any nonzero bit above DATA_W means wrap.
  localparam int unsigned WIDE_W = DATA_W + 3;
  logic [WIDE_W-1:0] wide_tgt;

  always_comb begin
    wide_tgt = {3'b000, pc} + WIDE_W'(4)
             + ({{(WIDE_W-IMM_W){imm[IMM_W-1]}}, imm} << 2);
    ovf = 1'b0;
    if (op == OP_BTGT) begin
      ovf = (wide_tgt >> DATA_W) != '0;
    end else if (op == OP_JUMP) begin
      ovf = &pc[DATA_W-1:2];
    end
  end
`endif

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender: one output register plus a one-entry skid buffer.
// IMM_EXT_OVF_EN carries the target-wrap flag through both entries; otherwise out_ovf is 0.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IMM_W  = DEF_IMM_W,
  parameter int unsigned JIDX_W = DEF_JIDX_W,
  parameter int unsigned OP_W   = DEF_OP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [JIDX_W-1:0] in_jidx,
  input  logic [DATA_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_illegal,
  output logic              out_ovf
);

  // Payload is {[ovf,] illegal, data}, so flag storage follows the feature build.
`ifdef IMM_EXT_OVF_EN
  localparam int unsigned PAY_W = DATA_W + 2;
`else
  localparam int unsigned PAY_W = DATA_W + 1;
`endif

  logic [DATA_W-1:0] core_data;
  logic              core_illegal;
  logic [PAY_W-1:0]  core_pay;

`ifdef IMM_EXT_OVF_EN
  logic core_ovf;
`endif

  imm_ext_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .JIDX_W (JIDX_W),
    .OP_W   (OP_W)
  ) u_core (
    .op      (in_op),
    .imm     (in_imm),
    .jidx    (in_jidx),
    .pc      (in_pc),
    .data    (core_data),
`ifdef IMM_EXT_OVF_EN
    .ovf     (core_ovf),
`endif
    .illegal (core_illegal)
  );

`ifdef IMM_EXT_OVF_EN
  assign core_pay = {core_ovf, core_illegal, core_data};
`else
  assign core_pay = {core_illegal, core_data};
`endif

  logic             out_valid_q, out_valid_d;
  logic [PAY_W-1:0] out_pay_q, out_pay_d;
  logic             skid_valid_q, skid_valid_d;
  logic [PAY_W-1:0] skid_pay_q, skid_pay_d;
  logic             accept;
  logic             load_out;

  always_comb begin
    accept       = in_valid && !skid_valid_q && !flush;
    load_out     = !out_valid_q || out_ready;
    out_valid_d  = out_valid_q;
    out_pay_d    = out_pay_q;
    skid_valid_d = skid_valid_q;
    skid_pay_d   = skid_pay_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (load_out) begin
      // A full skid blocks input, so only one source can feed the output per edge.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_pay_d    = skid_pay_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_pay_d = core_pay;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_pay_d   = core_pay;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_pay_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_pay_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_pay_q    <= out_pay_d;
      skid_valid_q <= skid_valid_d;
      skid_pay_q   <= skid_pay_d;
    end
  end

  assign in_ready    = !skid_valid_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_pay_q[DATA_W-1:0];
  assign out_illegal = out_pay_q[DATA_W];
`ifdef IMM_EXT_OVF_EN
  assign out_ovf     = out_pay_q[DATA_W+1];
`else
  assign out_ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: queue-based reference model checked every cycle plus directed literal checks.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_imm;
  logic [25:0] in_jidx;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_illegal;
  logic        out_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] data;
    logic        ill;
    logic        ovf;
  } exp_t;

  exp_t q[$];

  imm_ext_pipe #(
    .DATA_W (32),
    .IMM_W  (16),
    .JIDX_W (26),
    .OP_W   (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_imm      (in_imm),
    .in_jidx     (in_jidx),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_illegal (out_illegal),
    .out_ovf     (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference result from plain integer arithmetic on the op definitions.
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] imm,
                                 input logic [25:0] jidx, input logic [31:0] pc);
    exp_t   r;
    longint s_imm;
    longint pc4;
    longint full;
    longint d;
    s_imm = imm[15] ? longint'(imm) - 65536 : longint'(imm);
    pc4   = longint'(pc) + 4;
    d     = 0;
    r.ill = 1'b0;
    r.ovf = 1'b0;
    case (op)
      3'd0: d = longint'(imm);
      3'd1: d = s_imm;
      3'd2: d = longint'(imm) * 65536;
      3'd3: d = s_imm * 4;
      3'd4: begin
        d = (pc4 & 64'h0000_0000_F000_0000) | (longint'(jidx) * 4);
`ifdef IMM_EXT_OVF_EN
        r.ovf = pc4 >= 64'h1_0000_0000;
`endif
      end
      3'd5: begin
        full = pc4 + s_imm * 4;
        d    = full;
`ifdef IMM_EXT_OVF_EN
        r.ovf = (full < 0) || (full >= 64'h1_0000_0000);
`endif
      end
      default: r.ill = 1'b1;
    endcase
    r.data = d[31:0];
    return r;
  endfunction

  // Model update: at most two entries, input accepted only while fewer than two held.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else begin
      logic acc;
      acc = in_valid && (q.size() < 2);
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (acc) q.push_back(model(in_op, in_imm, in_jidx, in_pc));
    end
  end

  always @(negedge clk) begin
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    if (q.size() > 0 && out_valid) begin
      chk("out_data", out_data, q[0].data);
      chk("out_illegal", {31'd0, out_illegal}, {31'd0, q[0].ill});
      chk("out_ovf", {31'd0, out_ovf}, {31'd0, q[0].ovf});
    end
  end

  task automatic drive(input logic [2:0] op, input logic [15:0] imm,
                       input logic [25:0] jidx, input logic [31:0] pc);
    in_valid = 1'b1;
    in_op    = op;
    in_imm   = imm;
    in_jidx  = jidx;
    in_pc    = pc;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic exp_ovf_lit;

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_imm    = '0;
    in_jidx   = '0;
    in_pc     = '0;
    out_ready = 1'b1;
`ifdef IMM_EXT_OVF_EN
    exp_ovf_lit = 1'b1;
`else
    exp_ovf_lit = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    drive(3'd1, 16'h8000, '0, '0);
    chk("sign_ext", out_data, 32'hFFFF_8000);
    chk("sign_valid", {31'd0, out_valid}, 32'd1);
    drive(3'd0, 16'h8000, '0, '0);
    chk("zero_ext", out_data, 32'h0000_8000);
    drive(3'd2, 16'h1234, '0, '0);
    chk("lui", out_data, 32'h1234_0000);
    drive(3'd5, 16'hFFFF, '0, 32'h0000_3000);
    chk("btgt", out_data, 32'h0000_3000);
    drive(3'd4, 16'h0000, 26'h0000C01, 32'h0000_3000);
    chk("jump", out_data, 32'h0000_3004);
    drive(3'd3, 16'hFFFF, '0, '0);
    chk("sofs", out_data, 32'hFFFF_FFFC);
    drive(3'd6, 16'h1234, '0, 32'h0000_3000);
    chk("illegal_data", out_data, 32'd0);
    chk("illegal_flag", {31'd0, out_illegal}, 32'd1);
    drive(3'd0, 16'h0005, '0, '0);
    chk("illegal_clear", {31'd0, out_illegal}, 32'd0);
    chk("after_illegal", out_data, 32'h0000_0005);
    drive(3'd7, 16'hFFFF, '0, '0);
    chk("illegal7", {31'd0, out_illegal}, 32'd1);
    idle(2);

    // Backpressure: A, B accepted, C stalls until the output drains.
    out_ready = 1'b0;
    drive(3'd0, 16'h00A1, '0, '0);
    chk("bp_a_ready", {31'd0, in_ready}, 32'd1);
    drive(3'd0, 16'h00B2, '0, '0);
    chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
    drive(3'd0, 16'h00C3, '0, '0);
    chk("bp_hold_a", out_data, 32'h0000_00A1);
    @(negedge clk);
    chk("bp_stable_a", out_data, 32'h0000_00A1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_b", out_data, 32'h0000_00B2);
    chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("bp_c", out_data, 32'h0000_00C3);
    idle(2);

    // Flush with two held and a beat presented, then with one held and a beat presented.
    out_ready = 1'b0;
    drive(3'd0, 16'h00D4, '0, '0);
    drive(3'd0, 16'h00E5, '0, '0);
    flush = 1'b1;
    drive(3'd0, 16'h00F6, '0, '0);
    flush = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    drive(3'd0, 16'h0077, '0, '0);
    flush = 1'b1;
    drive(3'd0, 16'h0088, '0, '0);
    flush = 1'b0;
    chk("flush_drop", {31'd0, out_valid}, 32'd0);
    idle(2);

    // Asynchronous reset with two entries held.
    drive(3'd0, 16'h0011, '0, '0);
    drive(3'd0, 16'h0022, '0, '0);
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    // Target wrap cases.
    drive(3'd5, 16'h0000, '0, 32'hFFFF_FFFC);
    chk("wrap_data", out_data, 32'd0);
    chk("wrap_ovf", {31'd0, out_ovf}, {31'd0, exp_ovf_lit});
    drive(3'd5, 16'hFFFE, '0, 32'h0000_0000);
    chk("neg_data", out_data, 32'hFFFF_FFFC);
    chk("neg_ovf", {31'd0, out_ovf}, {31'd0, exp_ovf_lit});
    drive(3'd4, 16'h0000, 26'h0000003, 32'hFFFF_FFFC);
    chk("jwrap_data", out_data, 32'h0000_000C);
    chk("jwrap_ovf", {31'd0, out_ovf}, {31'd0, exp_ovf_lit});
    drive(3'd5, 16'h0001, '0, 32'h0000_1000);
    chk("no_ovf", {31'd0, out_ovf}, 32'd0);
    chk("btgt_fwd", out_data, 32'h0000_1008);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
